pipeline_ctrl: RTL and testbench
================================

// Module: pipeline_ctrl
// PURPOSE
//  Central stall/flush scheduler for the 5-stage core. Merges stall requests from IF/ID/EX/MEM
//  into the 6-bit stall bus (pc,if,id,ex,mem,wb) consumed by every pipeline register, and
//  sequences multi-cycle MUL/DIV occupancy of the HI/LO path. Takes the exception code leaving
//  MEM, issues a one-cycle flush and the redirect PC (exception vector or EPC on ERET).
// PARAMETERS
//  DIV_CYCLES  33           cycles a DIV/DIVU occupies EX before the result is valid
//  MUL_CYCLES  4            cycles a MULT/MULTU occupies EX
//  EXC_VECTOR  32'hBFC00380 redirect PC for every exception except ERET
//  ERET_CODE   5'h0E        excepttype value meaning ERET (redirect to cp0_epc)
// PORTS
//  clk           in   1   core clock
//  resetn        in   1   asynchronous active-low reset
//  stallreq_if   in   1   inst SRAM not ready
//  stallreq_id   in   1   load-use hazard
//  stallreq_mem  in   1   data SRAM not ready
//  md_start      in   1   EX issues MUL/DIV this cycle
//  md_is_div     in   1   1=DIV/DIVU, 0=MULT/MULTU; sampled with md_start
//  excepttype    in   5   MEM-stage exception code, 0 = none
//  cp0_epc       in   32  current EPC
//  stall         out  6   [0]pc [1]if [2]id [3]ex [4]mem [5]wb; 1=`Stop
//  flush         out  1   clear IF..MEM pipeline registers this cycle
//  new_pc        out  32  redirect target, valid while flush=1
//  md_busy       out  1   MUL/DIV unit occupied
//  md_done       out  1   one-cycle pulse: HI/LO result valid, EX may advance
// BEHAVIOUR
//  Reset (async, resetn=0): stall=0, flush=0, new_pc=0, md_busy=0, md_done=0, FSM=IDLE, cnt=0.
//  Stall encoding: stage k holds when stall[k]=1; a bubble enters k+1 when stall[k]=1 and
//   stall[k+1]=0. Output is a contiguous low-order mask set by the deepest requester:
//   stallreq_mem -> 6'b011111; ex_req -> 6'b001111; stallreq_id -> 6'b000111;
//   stallreq_if -> 6'b000011; none -> 6'b000000. stall[5] is always 0. Combinational from
//   inputs and FSM state (zero added latency).
//  ex_req = md_start | (state==BUSY); deasserted in the cycle md_done=1.
//  MUL/DIV FSM, states IDLE, BUSY, DONE:
//   IDLE: md_start=1 -> BUSY, cnt <= (md_is_div ? DIV_CYCLES : MUL_CYCLES)-2; md_busy=1.
//   BUSY: cnt decrements each cycle; cnt==0 -> DONE. md_start while BUSY is ignored.
//   DONE: md_done=1 for exactly one cycle, md_busy=0, -> IDLE. Total EX occupancy = N cycles
//    from md_start (cycle of md_start counts as 1, DONE is cycle N).
//   cnt width = $clog2(DIV_CYCLES); no wrap: cnt never decrements below 0.
//  Exception: excepttype!=0 -> flush=1 for that cycle only; new_pc = (excepttype==ERET_CODE) ?
//   cp0_epc : EXC_VECTOR. flush overrides all stall requests (stall=0 that cycle) and forces
//   FSM to IDLE, cnt=0, md_done suppressed (aborted op never writes HI/LO).
//  excepttype!=0 while stallreq_mem=1: MEM result incomplete -> keep stall, defer flush until
//   stallreq_mem=0 (excepttype is held by the stalled MEM register).
//  Back-to-back exceptions: each cycle with excepttype!=0 and no MEM stall produces a flush.
//  md_start in the same cycle as flush: ignored.
//  resetn asserted mid-operation: immediate return to reset values; no md_done pulse.
// STRUCTURE
//  Shared defines header: `StallBus (=6), `Stop/`NoStop, stage index constants, ERET code,
//   exception vector; no new typedefs.
//  One sub-module: md_sched (IDLE/BUSY/DONE FSM + counter, ports clk, resetn, start, is_div,
//   abort, busy, done). Stall-mask priority encoder and flush logic stay in the top.
// TESTING
//  Mask: stallreq_id=1 alone -> stall=6'b000111; add stallreq_mem=1 -> 6'b011111 same cycle.
//  DIV: md_start=1,md_is_div=1 at cycle T -> stall[3]=1 T..T+31, md_done=1 only at T+32,
//   stall=0 at T+32 with no other requests.
//  MULT: md_start,md_is_div=0 at T -> md_done at T+3; second md_start at T+1 ignored.
//  ERET: excepttype=5'h0E, cp0_epc=32'h8000_1234 -> flush=1, new_pc=32'h8000_1234, stall=0,
//   1 cycle; other code 5'h01 -> new_pc=32'hBFC00380.
//  Abort: exception at T+10 of a DIV -> md_busy=0 at T+11, no md_done ever; excepttype with
//   stallreq_mem=1 for 3 cycles -> flush in first cycle stallreq_mem=0.
//  Async reset: resetn low mid-DIV, between clock edges -> all outputs 0 immediately.

Source files
------------

// File: rtl/pipeline_ctrl_pkg.sv
// pipeline_ctrl_pkg
// Shared constants for the pipeline stall/flush scheduler: width of the
// stall bus, the stop/no-stop encoding, stage positions on the bus, the
// exception redirect constants and the MUL/DIV occupancy defaults.
// Ports: none (package).
package pipeline_ctrl_pkg;

  localparam int STALL_BUS = 6;

  localparam logic STOP    = 1'b1;
  localparam logic NO_STOP = 1'b0;

  // Bit positions on the stall bus; pc is bit 0 and wb is bit 5.
  localparam int STAGE_IF  = 1;
  localparam int STAGE_ID  = 2;
  localparam int STAGE_EX  = 3;
  localparam int STAGE_MEM = 4;

  localparam logic [4:0]  ERET_CODE_DEF  = 5'h0E;
  localparam logic [31:0] EXC_VECTOR_DEF = 32'hBFC00380;

  localparam int DIV_CYCLES_DEF = 33;
  localparam int MUL_CYCLES_DEF = 4;

  // A requester at stage 'deepest' freezes itself and everything upstream,
  // so the mask is contiguous from bit 0 up to and including 'deepest'.
  function automatic logic [STALL_BUS-1:0] stall_mask(input int deepest);
    logic [STALL_BUS-1:0] m;
    m = '0;
    for (int i = 0; i < STALL_BUS; i++) begin
      m[i] = (i <= deepest) ? STOP : NO_STOP;
    end
    return m;
  endfunction

endpackage

// File: rtl/pipeline_ctrl_md_sched.sv
// md_sched
// Occupancy sequencer for the multi-cycle MUL/DIV unit. An accepted start
// occupies EX for DIV_CYCLES or MUL_CYCLES cycles, with the start cycle
// counted as the first one and the DONE cycle as the last.
// Ports:
//   clk     in  core clock
//   resetn  in  asynchronous active-low reset
//   start   in  EX issues MUL/DIV this cycle (honoured only in IDLE)
//   is_div  in  1 = DIV/DIVU, 0 = MULT/MULTU, sampled with start
//   abort   in  pipeline flush; drops the operation and suppresses done
//   busy    out unit occupied (BUSY state)
//   done    out one-cycle pulse, HI/LO result valid
module md_sched
  import pipeline_ctrl_pkg::*;
#(
  parameter int DIV_CYCLES = DIV_CYCLES_DEF,
  parameter int MUL_CYCLES = MUL_CYCLES_DEF
) (
  input  logic clk,
  input  logic resetn,
  input  logic start,
  input  logic is_div,
  input  logic abort,
  output logic busy,
  output logic done
);

  localparam int CNT_W = $clog2(DIV_CYCLES);

  // Start and DONE cycles are not spent in BUSY, hence the minus two.
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 2);
  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 2);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } md_state_e;

  md_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // State and counter registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and outputs. BUSY leaves on the cycle whose decrement reaches
  // zero, so the loaded count equals the number of BUSY cycles. An abort
  // overrides everything, including a start in the same cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = BUSY;
          cnt_d   = is_div ? DIV_LOAD : MUL_LOAD;
        end
      end
      BUSY: begin
        busy = 1'b1;
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end
        if (cnt_q <= CNT_W'(1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    if (abort) begin
      state_d = IDLE;
      cnt_d   = '0;
      done    = 1'b0;
    end
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl
// Central stall/flush scheduler for the 5-stage core. Merges per-stage stall
// requests into the stall bus, sequences MUL/DIV occupancy of EX, and turns
// the exception code leaving MEM into a one-cycle flush plus redirect PC.
// Ports:
//   clk, resetn          core clock, asynchronous active-low reset
//   stallreq_if/_id/_mem stall requests from IF, ID and MEM
//   md_start, md_is_div  MUL/DIV issue from EX and its kind
//   excepttype           MEM-stage exception code, 0 = none
//   cp0_epc              current EPC, redirect target for ERET
//   stall[5:0]           pc,if,id,ex,mem,wb hold mask (1 = stop)
//   flush                clear IF..MEM registers this cycle
//   new_pc               redirect target, valid while flush is high
//   md_busy, md_done     MUL/DIV occupied / result-valid pulse
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int          DIV_CYCLES = DIV_CYCLES_DEF,
  parameter int          MUL_CYCLES = MUL_CYCLES_DEF,
  parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEF,
  parameter logic [4:0]  ERET_CODE  = ERET_CODE_DEF
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 stallreq_if,
  input  logic                 stallreq_id,
  input  logic                 stallreq_mem,
  input  logic                 md_start,
  input  logic                 md_is_div,
  input  logic [4:0]           excepttype,
  input  logic [31:0]          cp0_epc,
  output logic [STALL_BUS-1:0] stall,
  output logic                 flush,
  output logic [31:0]          new_pc,
  output logic                 md_busy,
  output logic                 md_done
);

  logic flush_now;
  logic ex_req;

  // A stalled MEM register still holds an incomplete instruction, so its
  // exception is taken only once the MEM stall releases.
  assign flush_now = resetn && (excepttype != 5'd0) && !stallreq_mem;

  md_sched #(
    .DIV_CYCLES(DIV_CYCLES),
    .MUL_CYCLES(MUL_CYCLES)
  ) u_md_sched (
    .clk   (clk),
    .resetn(resetn),
    .start (md_start),
    .is_div(md_is_div),
    .abort (flush_now),
    .busy  (md_busy),
    .done  (md_done)
  );

  // EX holds from the issue cycle through BUSY and releases on the done pulse.
  assign ex_req = (md_start || md_busy) && !md_done;

  // Deepest requester wins; a flush clears the whole bus. Outputs are forced
  // to zero while reset is held so nothing leaks from live request inputs.
  always_comb begin
    stall  = '0;
    flush  = 1'b0;
    new_pc = '0;
    if (!resetn) begin
      stall = '0;
    end else if (flush_now) begin
      flush  = 1'b1;
      new_pc = (excepttype == ERET_CODE) ? cp0_epc : EXC_VECTOR;
    end else if (stallreq_mem) begin
      stall = stall_mask(STAGE_MEM);
    end else if (ex_req) begin
      stall = stall_mask(STAGE_EX);
    end else if (stallreq_id) begin
      stall = stall_mask(STAGE_ID);
    end else if (stallreq_if) begin
      stall = stall_mask(STAGE_IF);
    end
  end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb_pipeline_ctrl
// Self-checking bench for pipeline_ctrl: directed scenarios followed by a
// randomized run, all checked against a cycle-level reference model that
// tracks a MUL/DIV operation by its age since issue.
module tb_pipeline_ctrl;

  logic        clk = 1'b0;
  logic        resetn;
  logic        stallreq_if, stallreq_id, stallreq_mem;
  logic        md_start, md_is_div;
  logic [4:0]  excepttype;
  logic [31:0] cp0_epc;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic        md_busy, md_done;

  int testCount = 0;
  int failCount = 0;

  // Reference model: an accepted operation of length N has age 1 on the
  // cycle after issue and produces its result when age reaches N-1.
  bit mdActive = 1'b0;
  int mdAge    = 0;
  int mdN      = 0;

  pipeline_ctrl dut (
    .clk         (clk),
    .resetn      (resetn),
    .stallreq_if (stallreq_if),
    .stallreq_id (stallreq_id),
    .stallreq_mem(stallreq_mem),
    .md_start    (md_start),
    .md_is_div   (md_is_div),
    .excepttype  (excepttype),
    .cp0_epc     (cp0_epc),
    .stall       (stall),
    .flush       (flush),
    .new_pc      (new_pc),
    .md_busy     (md_busy),
    .md_done     (md_done)
  );

  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    testCount++;
    assert (got === exp) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input bit ifr, input bit idr, input bit memr,
                               input bit st, input bit dv,
                               input logic [4:0] exc, input logic [31:0] epc);
    stallreq_if  = ifr;
    stallreq_id  = idr;
    stallreq_mem = memr;
    md_start     = st;
    md_is_div    = dv;
    excepttype   = exc;
    cp0_epc      = epc;
  endtask

  function automatic bit modelFlush();
    return resetn && (excepttype != 5'd0) && !stallreq_mem;
  endfunction

  task automatic checkOutput();
    bit          doneCyc;
    bit          flushE, busyE, doneE, exReq;
    logic [5:0]  stallE;
    logic [31:0] pcE;
    doneCyc = mdActive && (mdAge == mdN - 1);
    flushE  = modelFlush();
    busyE   = resetn && mdActive && !doneCyc;
    doneE   = resetn && doneCyc && !flushE;
    exReq   = busyE || (md_start && !mdActive);
    if (!resetn || flushE) stallE = 6'b000000;
    else if (stallreq_mem) stallE = 6'b011111;
    else if (exReq)        stallE = 6'b001111;
    else if (stallreq_id)  stallE = 6'b000111;
    else if (stallreq_if)  stallE = 6'b000011;
    else                   stallE = 6'b000000;
    pcE = !flushE ? 32'h0 : (excepttype == 5'h0E) ? cp0_epc : 32'hBFC00380;
    checkVal("stall", stall, stallE);
    checkVal("flush", flush, flushE);
    checkVal("new_pc", new_pc, pcE);
    checkVal("md_busy", md_busy, busyE);
    checkVal("md_done", md_done, doneE);
  endtask

  task automatic updateModel();
    bit doneCyc;
    doneCyc = mdActive && (mdAge == mdN - 1);
    if (!resetn || modelFlush()) begin
      mdActive = 1'b0;
    end else if (mdActive) begin
      if (doneCyc) mdActive = 1'b0;
      else mdAge++;
    end else if (md_start) begin
      mdActive = 1'b1;
      mdAge    = 1;
      mdN      = md_is_div ? 33 : 4;
    end
  endtask

  // Inputs are set 1 time unit after a rising edge; outputs are checked 3
  // units later, well clear of both edges.
  task automatic stepCycle();
    #3;
    checkOutput();
    @(posedge clk);
    updateModel();
    #1;
  endtask

  initial begin
    resetn = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 5'h00, 32'h0);
    #1 resetn = 1'b0;
    #1;
    checkOutput();
    checkVal("reset_stall", stall, 6'b000000);
    @(posedge clk);
    @(posedge clk);
    #1 resetn = 1'b1;

    // Stall mask priority
    applyStimulus(0, 1, 0, 0, 0, 5'h00, 32'h0);
    #2 checkVal("mask_id", stall, 6'b000111);
    stepCycle();
    applyStimulus(0, 1, 1, 0, 0, 5'h00, 32'h0);
    #2 checkVal("mask_mem", stall, 6'b011111);
    stepCycle();
    applyStimulus(1, 0, 0, 0, 0, 5'h00, 32'h0);
    stepCycle();

    // DIV: EX held for 32 cycles, result pulse on the 33rd
    for (int k = 0; k <= 32; k++) begin
      applyStimulus(0, 0, 0, k == 0, 1, 5'h00, 32'h0);
      #2;
      checkVal("div_stall_ex", stall[3], (k < 32) ? 1'b1 : 1'b0);
      checkVal("div_done", md_done, (k == 32) ? 1'b1 : 1'b0);
      stepCycle();
    end

    // MULT with a second issue that must be ignored
    for (int k = 0; k <= 4; k++) begin
      applyStimulus(0, 0, 0, (k == 0) || (k == 1), 0, 5'h00, 32'h0);
      #2 checkVal("mul_done", md_done, (k == 3) ? 1'b1 : 1'b0);
      stepCycle();
    end

    // ERET and ordinary exception redirect
    applyStimulus(0, 1, 0, 0, 0, 5'h0E, 32'h8000_1234);
    #2 checkVal("eret_pc", new_pc, 32'h8000_1234);
    stepCycle();
    applyStimulus(0, 0, 0, 0, 0, 5'h01, 32'h8000_1234);
    #2 checkVal("exc_pc", new_pc, 32'hBFC00380);
    stepCycle();
    applyStimulus(0, 0, 0, 0, 0, 5'h00, 32'h0);
    stepCycle();

    // Exception aborts a DIV at T+10
    for (int k = 0; k <= 40; k++) begin
      applyStimulus(0, 0, 0, k == 0, 1, (k == 10) ? 5'h01 : 5'h00, 32'h0);
      #2;
      checkVal("abort_done", md_done, 1'b0);
      if (k == 11) checkVal("abort_busy", md_busy, 1'b0);
      stepCycle();
    end

    // Exception deferred behind a MEM stall
    for (int k = 0; k < 4; k++) begin
      applyStimulus(0, 0, k < 3, 0, 0, 5'h03, 32'h0);
      #2 checkVal("defer_flush", flush, (k == 3) ? 1'b1 : 1'b0);
      stepCycle();
    end

    // Asynchronous reset in the middle of a DIV
    for (int k = 0; k < 6; k++) begin
      applyStimulus(0, 0, 0, k == 0, 1, 5'h00, 32'h0);
      stepCycle();
    end
    applyStimulus(1, 1, 0, 0, 0, 5'h00, 32'h0);
    #2 resetn = 1'b0;
    #1;
    mdActive = 1'b0;
    checkVal("areset_busy", md_busy, 1'b0);
    checkVal("areset_stall", stall, 6'b000000);
    checkOutput();
    @(posedge clk);
    #1 resetn = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 5'h00, 32'h0);
    stepCycle();

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      logic [4:0] exc;
      exc = 5'h00;
      if ($urandom_range(0, 19) == 0) begin
        exc = ($urandom_range(0, 1) == 0) ? 5'h0E : 5'($urandom_range(1, 31));
      end
      applyStimulus($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                    $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0,
                    $urandom_range(0, 1) == 1, exc, $urandom);
      stepCycle();
    end

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
